// File: rtl/pipe_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : pipe_stage_ctrl_pkg
// Brief   : Opcode constants, stage record and memory-op decode helpers.
// Rev     : 1.0
// ============================================================================
package pipe_stage_ctrl_pkg;

   localparam int CPU_OP_W  = 5;
   localparam int CPU_REG_W = 5;

   typedef logic [CPU_OP_W-1:0]  op_t;
   typedef logic [CPU_REG_W-1:0] reg_t;

   localparam op_t OP_LOAD  = 5'b01101;
   localparam op_t OP_STORE = 5'b01110;
   localparam op_t OP_PUSH  = 5'b01111;
   localparam op_t OP_POP   = 5'b10000;
   localparam op_t OP_NOP   = 5'b11111;

   typedef struct packed {
      op_t  op;
      reg_t regX;
      reg_t regIn0;
      reg_t regIn1;
      reg_t regData;
   } stage_t;

   localparam stage_t NOP_STAGE = '{op: OP_NOP, regX: '0, regIn0: '0, regIn1: '0, regData: '0};

   typedef enum logic [0:0] {
      MEM_IDLE = 1'b0,
      MEM_BUSY = 1'b1
   } mem_state_e;

   function automatic logic is_mem(input op_t op);
      return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_PUSH) || (op == OP_POP);
   endfunction

   function automatic logic is_rd(input op_t op);
      return (op == OP_LOAD) || (op == OP_POP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_ctrl_mem_handshake_fsm.sv
`default_nettype none
// ============================================================================
// Module : mem_handshake_fsm
// Brief  : M-stage memory request/ack handshake with saturating timeout.
// Rev    : 1.0
// ============================================================================
module mem_handshake_fsm
   import pipe_stage_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic m_is_mem_i,
   input  logic mem_ack_i,
   output logic mem_req_o,
   output logic mw_stall_o,
   output logic done_o,
   output logic mem_err_o
);

   localparam int               CNT_W    = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_w;

   assign timeout_w = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MEM_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_req_o = 1'b0;
      done_o    = 1'b0;
      mem_err_o = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            if (m_is_mem_i) begin
               mem_req_o = 1'b1;
               if (mem_ack_i) begin
                  done_o = 1'b1;
               end else begin
                  state_d = MEM_BUSY;
                  cnt_d   = '0;
               end
            end
         end
         MEM_BUSY: begin
            mem_req_o = 1'b1;
            // A real ack in the timeout cycle wins, so its data is kept.
            if (mem_ack_i) begin
               done_o  = 1'b1;
               state_d = MEM_IDLE;
            end else if (timeout_w) begin
               done_o    = 1'b1;
               mem_err_o = 1'b1;
               state_d   = MEM_IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   assign mw_stall_o = mem_req_o & ~done_o;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_stage_ctrl
// Brief  : D/X/M/W instruction-field pipeline with stall/bubble/flush control.
// Rev    : 1.0
// ============================================================================
module pipe_stage_ctrl
   import pipe_stage_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int OP_W        = 5,
   parameter int REG_W       = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OP_W-1:0]  dec_op,
   input  logic [REG_W-1:0] dec_regX,
   input  logic [REG_W-1:0] dec_regIn0,
   input  logic [REG_W-1:0] dec_regIn1,
   input  logic [REG_W-1:0] dec_regData,
   output logic             dec_ready,
   input  logic             flush,
   input  logic             fd_stall,
   input  logic             dx_stall,
   input  logic             xm_stall,
   output logic [OP_W-1:0]  d_op,
   output logic [REG_W-1:0] d_regIn0,
   output logic [REG_W-1:0] d_regIn1,
   output logic [OP_W-1:0]  x_op,
   output logic [REG_W-1:0] x_regX,
   output logic [REG_W-1:0] x_regIn0,
   output logic [REG_W-1:0] x_regIn1,
   output logic [OP_W-1:0]  m_op,
   output logic [REG_W-1:0] m_regX,
   output logic [REG_W-1:0] m_regData,
   output logic [OP_W-1:0]  w_op,
   output logic [REG_W-1:0] w_regOut,
   output logic             mem_req,
   input  logic             mem_ack,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      w_rdata,
   output logic             MW_stall,
   output logic             valid,
   output logic             mem_err
);

   stage_t      d_q, d_d, x_q, x_d;
   op_t         m_op_q, m_op_d, w_op_q, w_op_d;
   reg_t        m_regX_q, m_regX_d, m_regData_q, m_regData_d;
   reg_t        w_regX_q, w_regX_d;
   logic [31:0] w_rdata_q, w_rdata_d;
   logic        valid_q, valid_d;
   logic        flush_pend_q, flush_pend_d;

   stage_t      dec_stage_w;
   logic        d_load_w;
   logic        done_w;

   mem_handshake_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_fsm (
      .clk        (clk),
      .rst        (rst),
      .m_is_mem_i (is_mem(m_op_q) && (m_op_q != OP_NOP)),
      .mem_ack_i  (mem_ack),
      .mem_req_o  (mem_req),
      .mw_stall_o (MW_stall),
      .done_o     (done_w),
      .mem_err_o  (mem_err)
   );

   assign dec_stage_w = '{op: dec_op, regX: dec_regX, regIn0: dec_regIn0,
                          regIn1: dec_regIn1, regData: dec_regData};
   // D only takes new work when no stall of any depth is holding it.
   assign d_load_w    = ~(MW_stall | xm_stall | dx_stall | fd_stall);
   assign dec_ready   = d_load_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q          <= NOP_STAGE;
         x_q          <= NOP_STAGE;
         m_op_q       <= OP_NOP;
         m_regX_q     <= '0;
         m_regData_q  <= '0;
         w_op_q       <= OP_NOP;
         w_regX_q     <= '0;
         w_rdata_q    <= '0;
         valid_q      <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         d_q          <= d_d;
         x_q          <= x_d;
         m_op_q       <= m_op_d;
         m_regX_q     <= m_regX_d;
         m_regData_q  <= m_regData_d;
         w_op_q       <= w_op_d;
         w_regX_q     <= w_regX_d;
         w_rdata_q    <= w_rdata_d;
         valid_q      <= valid_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_comb begin
      d_d          = d_q;
      x_d          = x_q;
      m_op_d       = m_op_q;
      m_regX_d     = m_regX_q;
      m_regData_d  = m_regData_q;
      w_op_d       = OP_NOP;
      w_regX_d     = '0;
      w_rdata_d    = w_rdata_q;
      valid_d      = 1'b0;
      flush_pend_d = d_load_w ? 1'b0 : (flush_pend_q | flush);
      if (!MW_stall) begin
         w_op_d   = m_op_q;
         w_regX_d = m_regX_q;
         if (is_rd(m_op_q)) begin
            valid_d   = 1'b1;
            w_rdata_d = mem_err ? 32'h0 : mem_rdata;
         end
         if (xm_stall) begin
            m_op_d      = OP_NOP;
            m_regX_d    = '0;
            m_regData_d = '0;
         end else begin
            m_op_d      = x_q.op;
            m_regX_d    = x_q.regX;
            m_regData_d = x_q.regData;
            if (dx_stall) begin
               x_d = NOP_STAGE;
            end else begin
               x_d = d_q;
               if (!fd_stall) begin
                  d_d = (flush || flush_pend_q) ? NOP_STAGE : dec_stage_w;
               end
            end
         end
      end
   end

   assign d_op      = d_q.op;
   assign d_regIn0  = d_q.regIn0;
   assign d_regIn1  = d_q.regIn1;
   assign x_op      = x_q.op;
   assign x_regX    = x_q.regX;
   assign x_regIn0  = x_q.regIn0;
   assign x_regIn1  = x_q.regIn1;
   assign m_op      = m_op_q;
   assign m_regX    = m_regX_q;
   assign m_regData = m_regData_q;
   assign w_op      = w_op_q;
   assign w_regOut  = w_regX_q;
   assign w_rdata   = w_rdata_q;
   assign valid     = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_stage_ctrl
// Brief  : Directed self-checking bench for pipe_stage_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_pipe_stage_ctrl;

   localparam logic [4:0] NOP   = 5'b11111;
   localparam logic [4:0] LOAD  = 5'b01101;
   localparam logic [4:0] STORE = 5'b01110;
   localparam logic [4:0] ADD   = 5'b00001;
   localparam logic [4:0] SUB   = 5'b00010;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  dec_op, dec_regX, dec_regIn0, dec_regIn1, dec_regData;
   logic        dec_ready, flush, fd_stall, dx_stall, xm_stall;
   logic [4:0]  d_op, d_regIn0, d_regIn1;
   logic [4:0]  x_op, x_regX, x_regIn0, x_regIn1;
   logic [4:0]  m_op, m_regX, m_regData, w_op, w_regOut;
   logic        mem_req, mem_ack, MW_stall, valid, mem_err;
   logic [31:0] mem_rdata, w_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_stage_ctrl #(.MEM_TIMEOUT(16), .OP_W(5), .REG_W(5)) dut (
      .clk(clk), .rst(rst),
      .dec_op(dec_op), .dec_regX(dec_regX), .dec_regIn0(dec_regIn0),
      .dec_regIn1(dec_regIn1), .dec_regData(dec_regData), .dec_ready(dec_ready),
      .flush(flush), .fd_stall(fd_stall), .dx_stall(dx_stall), .xm_stall(xm_stall),
      .d_op(d_op), .d_regIn0(d_regIn0), .d_regIn1(d_regIn1),
      .x_op(x_op), .x_regX(x_regX), .x_regIn0(x_regIn0), .x_regIn1(x_regIn1),
      .m_op(m_op), .m_regX(m_regX), .m_regData(m_regData),
      .w_op(w_op), .w_regOut(w_regOut),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .w_rdata(w_rdata), .MW_stall(MW_stall), .valid(valid), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic [4:0] rx, input logic [4:0] r0,
                        input logic [4:0] r1, input logic [4:0] rd);
      dec_op = op; dec_regX = rx; dec_regIn0 = r0; dec_regIn1 = r1; dec_regData = rd;
   endtask

   initial begin
      rst = 1'b1; flush = 0; fd_stall = 0; dx_stall = 0; xm_stall = 0;
      mem_ack = 0; mem_rdata = 32'h0;
      drive(NOP, 0, 0, 0, 0);

      // Reset state
      tick(); tick();
      chk("rst_d_op", d_op, NOP);
      chk("rst_x_op", x_op, NOP);
      chk("rst_m_op", m_op, NOP);
      chk("rst_w_op", w_op, NOP);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_MW_stall", MW_stall, 0);
      chk("rst_valid", valid, 0);
      chk("rst_mem_err", mem_err, 0);
      chk("rst_w_rdata", w_rdata, 0);
      rst = 1'b0;

      // Four ALU ops, no stalls: each reaches W four edges after entry
      for (int i = 1; i <= 7; i++) begin
         if (i <= 4) drive(ADD, 5'(i), 0, 0, 0);
         else        drive(NOP, 0, 0, 0, 0);
         tick();
         if (i == 1) chk("alu_d_op", d_op, ADD);
         if (i >= 4) begin
            chk("alu_w_op", w_op, ADD);
            chk("alu_w_regOut", w_regOut, 32'(i - 3));
            chk("alu_valid", valid, 0);
         end
      end

      // LOAD r5 with three wait cycles, then ack with 0xDEAD
      drive(LOAD, 5, 0, 0, 5); tick();
      drive(ADD, 6, 6, 0, 0);  tick();
      drive(ADD, 7, 7, 0, 0);  tick();
      drive(NOP, 0, 0, 0, 0);
      chk("ld_mem_req", mem_req, 1);
      chk("ld_MW_stall0", MW_stall, 1);
      chk("ld_dec_ready", dec_ready, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("ld_d_frozen", d_regIn0, 7);
         chk("ld_x_frozen", x_regX, 6);
         chk("ld_m_frozen", m_op, LOAD);
         chk("ld_w_nop", w_op, NOP);
         chk("ld_valid0", valid, 0);
         if (k < 2) chk("ld_MW_stall", MW_stall, 1);
      end
      mem_ack = 1; mem_rdata = 32'hDEAD; #1;
      chk("ld_ack_MW_stall", MW_stall, 0);
      tick();
      mem_ack = 0; mem_rdata = 32'h0;
      chk("ld_w_op", w_op, LOAD);
      chk("ld_w_regOut", w_regOut, 5);
      chk("ld_valid", valid, 1);
      chk("ld_w_rdata", w_rdata, 32'hDEAD);
      chk("ld_m_next", m_regX, 6);
      chk("ld_x_next", x_regX, 7);
      tick();
      chk("ld_valid_drop", valid, 0);
      tick(); tick(); tick();

      // xm_stall for one cycle with ADD r8 in X
      drive(ADD, 8, 8, 0, 0); tick();
      drive(5'd3, 10, 10, 0, 0); tick();
      drive(NOP, 0, 0, 0, 0);
      xm_stall = 1; tick(); xm_stall = 0;
      chk("xm_x_op", x_op, ADD);
      chk("xm_x_regX", x_regX, 8);
      chk("xm_m_op", m_op, NOP);
      chk("xm_d_op", d_op, 3);
      chk("xm_d_regIn0", d_regIn0, 10);
      tick();
      chk("xm_rel_m_op", m_op, ADD);
      chk("xm_rel_x_op", x_op, 3);

      // dx_stall with SUB r9 in X
      drive(SUB, 9, 9, 0, 0); tick();
      drive(5'd4, 11, 11, 0, 0); tick();
      drive(NOP, 0, 0, 0, 0);
      dx_stall = 1; tick(); dx_stall = 0;
      chk("dx_d_op", d_op, 4);
      chk("dx_d_regIn0", d_regIn0, 11);
      chk("dx_x_op", x_op, NOP);
      chk("dx_m_op", m_op, SUB);
      chk("dx_m_regX", m_regX, 9);

      // Flush arriving while fd_stall holds D
      fd_stall = 1; flush = 1;
      drive(5'd5, 12, 12, 13, 0); #1;
      chk("fl_dec_ready", dec_ready, 0);
      tick();
      chk("fl_d_held", d_op, 4);
      chk("fl_x_op", x_op, 4);
      chk("fl_x_regX", x_regX, 11);
      fd_stall = 0; flush = 0; #1;
      chk("fl_dec_ready1", dec_ready, 1);
      tick();
      chk("fl_d_nop", d_op, NOP);
      chk("fl_d_regIn0", d_regIn0, 0);
      tick();
      chk("fl_pend_clr", d_op, 5);
      chk("fl_pend_regIn1", d_regIn1, 13);
      drive(NOP, 0, 0, 0, 0);
      tick(); tick(); tick(); tick();

      // STORE with no ack: timeout in the 16th BUSY cycle
      drive(STORE, 0, 0, 0, 7); tick();
      drive(NOP, 0, 0, 0, 0); tick(); tick();
      chk("st_m_regData", m_regData, 7);
      for (int k = 0; k < 16; k++) begin
         chk("st_wait_err", mem_err, 0);
         chk("st_wait_stall", MW_stall, 1);
         tick();
      end
      chk("st_err_pulse", mem_err, 1);
      chk("st_err_stall", MW_stall, 0);
      chk("st_err_m_op", m_op, STORE);
      tick();
      chk("st_err_clr", mem_err, 0);
      chk("st_w_op", w_op, STORE);
      chk("st_valid", valid, 0);
      chk("st_m_op", m_op, NOP);
      chk("st_mem_req", mem_req, 0);

      // Reset in the middle of a BUSY load, with an ack in flight
      drive(LOAD, 3, 0, 0, 3); tick();
      drive(ADD, 4, 0, 0, 0); tick();
      drive(NOP, 0, 0, 0, 0); tick(); tick();
      chk("rb_busy_req", mem_req, 1);
      rst = 1; mem_ack = 1; mem_rdata = 32'hBEEF;
      tick();
      chk("rb_mem_req", mem_req, 0);
      chk("rb_d_op", d_op, NOP);
      chk("rb_x_op", x_op, NOP);
      chk("rb_m_op", m_op, NOP);
      chk("rb_w_op", w_op, NOP);
      chk("rb_valid", valid, 0);
      chk("rb_w_rdata", w_rdata, 0);
      rst = 0; mem_ack = 0; mem_rdata = 32'h0;
      tick();
      chk("rb_mem_req_after", mem_req, 0);
      chk("rb_valid_after", valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
